control_unit: RTL

Hardwired control unit that sequences the phase-1 datapath: register file R0–R15, PC, MAR, MDR, IR, Y, Z (ZHI/ZLO), HI/LO and the ALU on the shared bus. It runs one instruction at a time through fetch (T0–T2) and an opcode-dependent execute sequence (T3–T6). In each step it drives exactly the datapath strobes the bench currently drives by hand. It replaces hand-written per-instruction state machines in the test benches and is the controller the phase-2 top level instantiates.

---
 rtl/control_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// Hardwired control unit for the phase-1 datapath: fetch in T0-T2, then an
// opcode-dependent execute sequence in T3-T6, with Moore-decoded strobes.
module control_unit (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic        Stop,
    input  logic        Mem_ready,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        ZHIout,
    output logic        ZLOout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        PCin,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        LOin,
    output logic        IncrementPC,
    output logic        Read,
    output logic        Rout,
    output logic        Rin,
    output logic [3:0]  Rout_sel,
    output logic [3:0]  Rin_sel,
    output logic [4:0]  ALUControl,
    output logic        Run,
    output logic        Halted,
    output logic        Illegal
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    state_t state, state_nxt;
    logic   t1_stall;

    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       is_bin, is_un, is_md, is_nop, is_halt;

    assign op = IR[31:27];
    assign ra = IR[26:23];
    assign rb = IR[22:19];
    assign rc = IR[18:15];

    assign is_bin  = (op < 5'd12);
    assign is_un   = (op == 5'd12) || (op == 5'd13);
    assign is_md   = (op == 5'd14) || (op == 5'd15);
    assign is_nop  = (op == 5'd26);
    assign is_halt = (op == 5'd27);

    // t1_stall marks every T1 cycle after the first, so PCin fires once per fetch
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= S_IDLE;
            t1_stall <= 1'b0;
        end else begin
            state    <= state_nxt;
            t1_stall <= (state == S_T1) && !Mem_ready;
        end
    end

    always_comb begin
        state_t last_nxt;
        last_nxt  = Stop ? S_HALT : S_T0;
        state_nxt = state;
        case (state)
            S_IDLE: if (Start) state_nxt = S_T0;
            S_T0:   state_nxt = S_T1;
            S_T1:   if (Mem_ready) state_nxt = S_T2;
            S_T2:   state_nxt = S_T3;
            S_T3: begin
                if (is_halt)                       state_nxt = S_HALT;
                else if (is_bin || is_un || is_md) state_nxt = S_T4;
                else                               state_nxt = last_nxt;
            end
            S_T4:   state_nxt = is_un ? last_nxt : S_T5;
            S_T5:   state_nxt = is_md ? S_T6 : last_nxt;
            S_T6:   state_nxt = last_nxt;
            S_HALT: if (Start && !Stop) state_nxt = S_T0;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        PCout = 1'b0; ZHIout = 1'b0; ZLOout = 1'b0; MDRout = 1'b0;
        HIout = 1'b0; LOout = 1'b0;
        PCin = 1'b0; MARin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
        Yin = 1'b0; Zin = 1'b0; HIin = 1'b0; LOin = 1'b0;
        IncrementPC = 1'b0; Read = 1'b0; Rout = 1'b0; Rin = 1'b0;
        Rout_sel = '0; Rin_sel = '0; ALUControl = '0;
        Run = 1'b0; Halted = 1'b0; Illegal = 1'b0;
        case (state)
            S_T0: begin
                Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncrementPC = 1'b1; Zin = 1'b1;
            end
            S_T1: begin
                Run = 1'b1; ZLOout = 1'b1; Read = 1'b1; MDRin = 1'b1;
                PCin = !t1_stall;
            end
            S_T2: begin
                Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                Run = 1'b1;
                if (is_bin) begin
                    Rout = 1'b1; Rout_sel = rb; Yin = 1'b1;
                end else if (is_un) begin
                    Rout = 1'b1; Rout_sel = rb; Zin = 1'b1; ALUControl = op;
                end else if (is_md) begin
                    Rout = 1'b1; Rout_sel = ra; Yin = 1'b1;
                end else if (!is_nop && !is_halt) begin
                    Illegal = 1'b1;
                end
            end
            S_T4: begin
                Run = 1'b1;
                if (is_bin || is_md) begin
                    Rout = 1'b1; Rout_sel = is_bin ? rc : rb; Zin = 1'b1; ALUControl = op;
                end else if (is_un) begin
                    ZLOout = 1'b1; Rin = 1'b1; Rin_sel = ra;
                end
            end
            S_T5: begin
                Run = 1'b1;
                if (is_bin) begin
                    ZLOout = 1'b1; Rin = 1'b1; Rin_sel = ra;
                end else if (is_md) begin
                    ZLOout = 1'b1; LOin = 1'b1;
                end
            end
            S_T6: begin
                Run = 1'b1; ZHIout = 1'b1; HIin = 1'b1;
            end
            S_HALT: Halted = 1'b1;
            default: ;
        endcase
    end

endmodule
